// File: rtl/instr_fetch.sv
// ============================================================================
// Module   : instr_fetch
// Purpose  : PC consumer: fetches over req/ack, buffers words in a FIFO, drives
//            the PC's next value. Optional macro: FETCH_ALIGN_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int INSTR_BYTES = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] pc_addr_i,
  output logic [ADDR_W-1:0] next_address_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_addr_o,
  output logic              fetch_fault_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] data_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              issue, push, pop, fault_block;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;
  logic misaligned;

  assign misaligned    = (pc_addr_i[1:0] != 2'b00);
  assign fault_block   = fault_q | misaligned;
  assign fetch_fault_o = fault_q;

  always_comb begin
    fault_d = fault_q;
    if (redirect_i)                            fault_d = 1'b0;
    else if (state_q == S_IDLE && misaligned)  fault_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) fault_q <= 1'b0;
    else         fault_q <= fault_d;
  end
`else
  assign fault_block   = 1'b0;
  assign fetch_fault_o = 1'b0;
`endif

  assign issue = (state_q == S_IDLE) && (count_q < C_DEPTH) && !redirect_i && !fault_block;
  assign push  = (state_q == S_REQ) && mem_ack_i && !redirect_i;
  assign pop   = (count_q != '0) && instr_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // A redirect with no ack leaves a stale request in flight that must be drained.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (issue) state_d = S_REQ;
      S_REQ: begin
        if (mem_ack_i)       state_d = S_IDLE;
        else if (redirect_i) state_d = S_DROP;
      end
      S_DROP:  if (mem_ack_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o      = (state_q != S_IDLE);
    next_address_o = pc_addr_i;
    if (!rst_ni)
      next_address_o = '0;
    else if (redirect_i)
      next_address_o = redirect_addr_i;
    else if (state_q == S_REQ && mem_ack_i)
      next_address_o = mem_addr_q + ADDR_W'(INSTR_BYTES);
  end

  assign mem_addr_d = issue ? pc_addr_i : mem_addr_q;
  assign mem_addr_o = mem_addr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_addr_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      mem_addr_q <= mem_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      data_q[wr_ptr_q] <= mem_rdata_i;
      addr_q[wr_ptr_q] <= mem_addr_q;
    end
  end

  assign instr_valid_o = (count_q != '0);
  assign instr_o       = data_q[rd_ptr_q];
  assign instr_addr_o  = addr_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Directed and random checks of instr_fetch against a queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, mem_ack, redirect, instr_ready;
  logic [31:0] pc_addr, mem_rdata, redirect_addr;
  logic [31:0] next_address, mem_addr, instr, instr_addr;
  logic        mem_req, instr_valid, fetch_fault;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(DEPTH), .INSTR_BYTES(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .pc_addr_i(pc_addr), .next_address_o(next_address),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .redirect_i(redirect), .redirect_addr_i(redirect_addr), .instr_valid_o(instr_valid),
    .instr_ready_i(instr_ready), .instr_o(instr), .instr_addr_o(instr_addr),
    .fetch_fault_o(fetch_fault)
  );

  int passed = 0, failed = 0, total = 0;

  // Reference model: one outstanding-request flag, a stale flag, and a queue.
  logic [31:0] q_a[$], q_d[$];
  logic        busy, stale, fault_m, rd_fixed;
  logic [31:0] req_addr, pc_m, exp_next, rd_val;
  int          lat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q_a.delete(); q_d.delete();
    busy = 1'b0; stale = 1'b0; fault_m = 1'b0;
    req_addr = '0; pc_m = '0; lat = 0;
  endtask

  task automatic model_edge();
    logic issue, pop;
    issue = !busy && (q_a.size() < DEPTH) && !redirect && !fault_m &&
            !(ALIGN && pc_addr[1:0] != 2'b00);
    pop   = (q_a.size() != 0) && instr_ready;
    if (redirect) begin
      q_a.delete(); q_d.delete();
    end else begin
      if (pop) begin void'(q_a.pop_front()); void'(q_d.pop_front()); end
      if (busy && !stale && mem_ack) begin q_a.push_back(req_addr); q_d.push_back(mem_rdata); end
    end
    if (ALIGN) begin
      if (redirect) fault_m = 1'b0;
      else if (!busy && pc_addr[1:0] != 2'b00) fault_m = 1'b1;
    end
    if (busy) begin
      if (mem_ack) begin busy = 1'b0; stale = 1'b0; end
      else if (redirect) stale = 1'b1;
    end else if (issue) begin
      busy = 1'b1; req_addr = pc_addr; lat = $urandom_range(0, 3);
    end
    pc_m = exp_next;
  endtask

  task automatic check_outputs();
    if (!rst_n)                           exp_next = '0;
    else if (redirect)                    exp_next = redirect_addr;
    else if (busy && !stale && mem_ack)   exp_next = req_addr + 32'd4;
    else                                  exp_next = pc_addr;
    chk("mem_req",      32'(mem_req),      32'(busy));
    chk("mem_addr",     mem_addr,          req_addr);
    chk("instr_valid",  32'(instr_valid),  32'(q_a.size() != 0));
    chk("next_address", next_address,      exp_next);
    chk("fetch_fault",  32'(fetch_fault),  32'(fault_m));
    if (q_a.size() != 0) begin
      chk("instr",      instr,      q_d[0]);
      chk("instr_addr", instr_addr, q_a[0]);
    end
  endtask

  // ackc: -1 random latency, 0 no ack, 1 ack if a request is outstanding.
  task automatic step(input logic rst_v, input logic redir, input logic [31:0] raddr,
                      input logic rdy, input int ackc, input logic setpc, input logic [31:0] pcv);
    @(negedge clk);
    if (!rst_n) model_reset(); else model_edge();
    rst_n = rst_v;
    if (!rst_v) model_reset();
    pc_addr       = setpc ? pcv : pc_m;
    redirect      = redir;
    redirect_addr = raddr;
    instr_ready   = rdy;
    mem_ack       = 1'b0;
    if (rst_v && busy) begin
      if (ackc < 0) begin
        if (lat == 0) mem_ack = 1'b1; else lat--;
      end else mem_ack = (ackc == 1);
    end
    mem_rdata = rd_fixed ? rd_val : $urandom;
    #1;
    check_outputs();
  endtask

  initial begin
    rst_n = 1'b0; mem_ack = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    pc_addr = '0; mem_rdata = '0; redirect_addr = '0;
    rd_fixed = 1'b1; rd_val = 32'hDEAD_BEEF; exp_next = '0;
    model_reset();
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Fetch at 0 with ack two cycles after the request, then 4, 8, C.
    step(1, 0, 0, 0, 0, 1, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    chk("t2_next_in_ack", next_address, 32'h4);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("t2_head_instr", instr, 32'hDEAD_BEEF);
    chk("t2_head_addr",  instr_addr, 32'h0);
    rd_fixed = 1'b0;
    step(1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1, 0, 0);
    end
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("t3_full_no_req", 32'(mem_req), 32'h0);
    chk("t3_pc_held",     next_address, 32'h10);
    step(1, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("t3_refill_req",  32'(mem_req), 32'h1);
    chk("t3_refill_addr", mem_addr, 32'h10);

    // Asynchronous reset while the request at 0x10 is outstanding.
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t1_req_drop", 32'(mem_req), 32'h0);
    check_outputs();
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 32'h20);
    step(1, 0, 0, 0, 1, 0, 0);
    chk("t1_first_addr", mem_addr, 32'h20);

    // Redirect to 0x40 while the request at 0x8 is outstanding.
    step(1, 0, 0, 0, 0, 1, 32'h8);
    step(1, 1, 32'h40, 0, 0, 0, 0);
    chk("t4_next_redir", next_address, 32'h40);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("t4_drop_addr",  mem_addr, 32'h8);
    chk("t4_fifo_clear", 32'(instr_valid), 32'h0);
    step(1, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("t4_new_addr", mem_addr, 32'h40);
    step(1, 0, 0, 0, 1, 0, 0);

    // Redirect coincident with ack and a decoder pop.
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h100, 1, 1, 0, 0);
    chk("t5_next_redir", next_address, 32'h100);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("t5_count_zero", 32'(instr_valid), 32'h0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("t5_resume_addr", mem_addr, 32'h100);
    step(1, 0, 0, 0, 1, 0, 0);

    // Misaligned PC: fault and hold when the check is built in, fetch otherwise.
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 32'h6);
    step(1, 0, 0, 0, 1, 0, 0);
    chk("t6_req",   32'(mem_req),     32'(!ALIGN));
    chk("t6_fault", 32'(fetch_fault), 32'(ALIGN));
    step(1, 1, 32'h8, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    chk("t6_fault_clr",  32'(fetch_fault), 32'h0);
    chk("t6_fetch_addr", mem_addr, 32'h8);

    // Random traffic, including redirects near the top of the address space.
    for (int i = 0; i < 600; i++) begin
      logic        rd;
      logic [31:0] ra;
      rd = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) ra = 32'hFFFF_FFF8 | 32'($urandom_range(0, 1) << 2);
      else                           ra = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) ra[1:0] = 2'($urandom_range(1, 3));
      step(1, rd, ra, 1'($urandom_range(0, 1)), -1, 0, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Consumer end of the PC interface.
- Takes the PC's current address, fetches from instruction memory over a req/ack handshake, and buffers fetched words in a small FIFO for the decoder.
- Computes the PC's next value (sequential +4 or redirect target) and drives it back to the PC's new_address input.
- Sits between PC and decode stage.

Parameters:
- ADDR_W, 32, address width (matches PC width)
- DATA_W, 32, instruction word width
- FIFO_DEPTH, 4, instruction buffer entries; power of 2, >= 2
- INSTR_BYTES, 4, address increment per fetched instruction

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- pc_addr  in  ADDR_W  current PC value (PC output)
- next_address  out  ADDR_W  value PC loads on next edge
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_W  memory read address, stable while mem_req high
- mem_ack  in  1  single-cycle read completion
- mem_rdata  in  DATA_W  read data, valid when mem_ack high
- redirect  in  1  branch/jump redirect, single cycle
- redirect_addr  in  ADDR_W  redirect target
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  decoder accepts head
- instr  out  DATA_W  head instruction word
- instr_addr  out  ADDR_W  address of head instruction
- fetch_fault  out  1  misaligned fetch flag (see Optional Feature)

Behaviour:
- Reset (reset low, async):
  - state=IDLE, FIFO count=0, mem_req=0, mem_addr=0, instr_valid=0, fetch_fault=0, next_address=0.
  - Any outstanding request is abandoned; mem_req drops immediately.
- States:
  - IDLE: if count < FIFO_DEPTH and no redirect, latch mem_addr=pc_addr, mem_req=1, go REQ next cycle. Else stay.
  - REQ: mem_req=1, mem_addr held.
    - On mem_ack (no redirect): push {mem_addr, mem_rdata}, mem_req=0, go IDLE.
    - On redirect without ack: go DROP.
    - On redirect with ack: discard data, go IDLE.
  - DROP: mem_req held 1 at the stale address until mem_ack. The ack's data is discarded, then go IDLE. No new request is issued in DROP.
- Handshake: mem_req never deasserts before mem_ack is sampled. Exactly one request outstanding. Peak throughput is 1 fetch per 2 cycles.
- next_address (combinational), by priority:
  1. redirect_addr when redirect=1.
  2. mem_addr + INSTR_BYTES when mem_ack in REQ.
  3. pc_addr otherwise (PC holds).
- Arithmetic: addition is modulo 2^ADDR_W, so 0xFFFFFFFC+4 = 0x00000000.
- FIFO:
  - instr_valid = (count != 0); instr/instr_addr show the head.
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Issue only when count < FIFO_DEPTH, so a push never overflows. A pop in the push cycle is legal at any count.
- Redirect:
  - Clears the FIFO in the same edge (count=0, instr_valid=0 next cycle). A simultaneous pop is ignored.
  - Redirect has priority over push.
- Empty FIFO with instr_ready=1: no effect.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - In IDLE, if pc_addr[1:0] != 0, no request is issued and fetch_fault sets.
  - fetch_fault is sticky; it clears only on redirect or reset.
  - While set, next_address = pc_addr and no fetch occurs.
- Undefined: no alignment check, addresses pass unchanged, fetch_fault tied 0.

Test Plan:
1. Reset low mid-REQ with mem_addr=0x10 -> mem_req=0 immediately; instr_valid=0, next_address=0 while low; first request after release uses pc_addr.
2. pc_addr=0, memory acks 2 cycles after req with rdata=0xDEADBEEF -> FIFO head instr=0xDEADBEEF, instr_addr=0, next_address=4 in ack cycle; PC steps 0,4,8 over successive fetches.
3. instr_ready=0, FIFO_DEPTH=4 -> exactly 4 fetches (addr 0,4,8,C), then mem_req stays 0. One pop -> one new request at 0x10.
4. Redirect to 0x40 while REQ at 0x8 is outstanding -> FIFO cleared, next_address=0x40, ack at 0x8 discarded in DROP, next request mem_addr=0x40.
5. Redirect coincident with mem_ack and decoder pop -> data not pushed, count=0, next_address=redirect_addr.
6. With FETCH_ALIGN_CHECK_EN, pc_addr=0x6 -> no mem_req, fetch_fault=1 held; redirect to 0x8 -> fetch_fault=0, fetch at 0x8. Without the macro, fetch at 0x6 proceeds.
